// File: rtl/debounce_multi_if.sv
// rtl/debounce_multi_if.sv - grouped tick/input/output signals of the multi-channel debouncer
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic                tick;
  logic [CHANNELS-1:0] noisy;
  logic                glitch_clr;
  logic [CHANNELS-1:0] debounced;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [15:0]         glitch_count;

  modport master (
    output tick, noisy, glitch_clr,
    input  debounced, rise, fall, glitch_count
  );

  modport slave (
    input  tick, noisy, glitch_clr,
    output debounced, rise, fall, glitch_count
  );
endinterface

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - per-channel synchronise + press/release qualification FSM with shared glitch counter
module debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int PRESS_TICKS   = 1000000,
  parameter int RELEASE_TICKS = 1000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic            clk,
  input  logic            reset,
  debounce_multi_if.slave bus
);

  localparam int MAX_TICKS = (PRESS_TICKS > RELEASE_TICKS) ? PRESS_TICKS : RELEASE_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] PRESS_LAST   = TW'(PRESS_TICKS - 1);
  localparam logic [TW-1:0] RELEASE_LAST = TW'(RELEASE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [TW-1:0]       timer_q [CHANNELS];
  logic [TW-1:0]       timer_d [CHANNELS];
  logic [CHANNELS-1:0] debounced_q, debounced_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [15:0]         glitch_count_q, glitch_count_d;

  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] abort;
  logic [6:0]          abort_num;
  logic [15:0]         glitch_base;
  logic [16:0]         glitch_sum;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift each raw input through the synchroniser chain.
  always_comb begin
    sync_d[0] = bus.noisy;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Per-channel qualification FSM; a level change on s during PRESS/RELEASE is an abort.
  always_comb begin
    abort = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (s[i]) begin
            state_d[i] = ST_PRESS;
            timer_d[i] = '0;
          end
        end
        ST_PRESS: begin
          if (!s[i]) begin
            state_d[i] = ST_IDLE;
            abort[i]   = 1'b1;
          end else if (bus.tick) begin
            if (timer_q[i] == PRESS_LAST) begin
              state_d[i] = ST_HELD;
            end else begin
              timer_d[i] = timer_q[i] + TW'(1);
            end
          end
        end
        ST_HELD: begin
          if (!s[i]) begin
            state_d[i] = ST_RELEASE;
            timer_d[i] = '0;
          end
        end
        ST_RELEASE: begin
          if (s[i]) begin
            state_d[i] = ST_HELD;
            abort[i]   = 1'b1;
          end else if (bus.tick) begin
            if (timer_q[i] == RELEASE_LAST) begin
              state_d[i] = ST_IDLE;
            end else begin
              timer_d[i] = timer_q[i] + TW'(1);
            end
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Debounced level follows the next state so it, rise and fall land on the same edge.
  always_comb begin
    debounced_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      debounced_d[i] = (state_d[i] == ST_HELD) || (state_d[i] == ST_RELEASE);
    end
    rise_d = debounced_d & ~debounced_q;
    fall_d = ~debounced_d & debounced_q;
  end

  // Add this cycle's aborts from all channels to the (optionally cleared) count, saturating.
  always_comb begin
    abort_num = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      abort_num = abort_num + 7'(abort[i]);
    end
    glitch_base    = bus.glitch_clr ? 16'h0000 : glitch_count_q;
    glitch_sum     = {1'b0, glitch_base} + 17'(abort_num);
    glitch_count_d = glitch_sum[16] ? 16'hFFFF : glitch_sum[15:0];
  end

  // State register; reset drops everything immediately so no partial qualification survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        timer_q[i] <= '0;
      end
      debounced_q    <= '0;
      rise_q         <= '0;
      fall_q         <= '0;
      glitch_count_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      debounced_q    <= debounced_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      glitch_count_q <= glitch_count_d;
    end
  end

  assign bus.debounced    = debounced_q;
  assign bus.rise         = rise_q;
  assign bus.fall         = fall_q;
  assign bus.glitch_count = glitch_count_q;

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - table, directed and randomized model checks for debounce_multi
module tb_debounce_multi;

  localparam int CH = 4;
  localparam int PT = 4;
  localparam int RT = 3;
  localparam int SS = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  debounce_multi_if #(.CHANNELS(CH)) bus ();

  debounce_multi #(
    .CHANNELS(CH), .PRESS_TICKS(PT), .RELEASE_TICKS(RT), .SYNC_STAGES(SS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CH-1:0] any_rise, any_fall;

  // Reference model: synchroniser as delayed copies, each channel keeps its debounced
  // level and a count of ticks spent disagreeing (-1 when not qualifying).
  logic [CH-1:0] m_d1, m_d2, m_deb, m_rise, m_fall;
  int            m_cnt [CH];
  int            m_gc;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_deb = '0; m_rise = '0; m_fall = '0; m_gc = 0;
    for (int i = 0; i < CH; i++) m_cnt[i] = -1;
  endtask

  task automatic model_step(input logic [CH-1:0] nz, input logic tk, input logic clr);
    logic [CH-1:0] sv, nd;
    int aborts, need;
    sv = m_d2; nd = m_deb; aborts = 0;
    for (int i = 0; i < CH; i++) begin
      need = m_deb[i] ? RT : PT;
      if (m_cnt[i] < 0) begin
        if (sv[i] != m_deb[i]) m_cnt[i] = 0;
      end else if (sv[i] == m_deb[i]) begin
        aborts++;
        m_cnt[i] = -1;
      end else if (tk) begin
        if (m_cnt[i] + 1 == need) begin
          nd[i] = ~m_deb[i];
          m_cnt[i] = -1;
        end else begin
          m_cnt[i]++;
        end
      end
    end
    m_rise = nd & ~m_deb;
    m_fall = ~nd & m_deb;
    m_deb  = nd;
    m_gc   = (clr ? 0 : m_gc) + aborts;
    if (m_gc > 65535) m_gc = 65535;
    m_d2 = m_d1;
    m_d1 = nz;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: advance the model with the present inputs, sample DUT 2ns after the edge.
  task automatic step();
    if (!reset) model_step(bus.noisy, bus.tick, bus.glitch_clr);
    @(posedge clk);
    #2;
    any_rise |= bus.rise;
    any_fall |= bus.fall;
    chk("model", {4'h0, bus.debounced, bus.rise, bus.fall, bus.glitch_count},
        {4'h0, m_deb, m_rise, m_fall, m_gc[15:0]});
  endtask

  // Asynchronous reset pulse between edges; outputs must clear with no clock edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_async", {4'h0, bus.debounced, bus.rise, bus.fall, bus.glitch_count}, 32'h0);
    #1;
    reset = 1'b0;
    any_rise = '0;
    any_fall = '0;
  endtask

  typedef struct {
    logic [CH-1:0] noisy;
    logic          tick;
    logic          clr;
    int            ncyc;
    logic [CH-1:0] exp_deb;
    logic [15:0]   exp_gc;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{4'b0000, 1'b1, 1'b0, 3,  4'b0000, 16'd0};
    vt[1]  = '{4'b0101, 1'b1, 1'b0, 7,  4'b0101, 16'd0};
    vt[2]  = '{4'b0101, 1'b1, 1'b0, 5,  4'b0101, 16'd0};
    vt[3]  = '{4'b0000, 1'b1, 1'b0, 5,  4'b0101, 16'd0};
    vt[4]  = '{4'b0000, 1'b1, 1'b0, 1,  4'b0000, 16'd0};
    vt[5]  = '{4'b1111, 1'b0, 1'b0, 10, 4'b0000, 16'd0};
    vt[6]  = '{4'b1111, 1'b1, 1'b0, 3,  4'b0000, 16'd0};
    vt[7]  = '{4'b1111, 1'b1, 1'b0, 1,  4'b1111, 16'd0};
    vt[8]  = '{4'b0000, 1'b1, 1'b0, 2,  4'b1111, 16'd0};
    vt[9]  = '{4'b1111, 1'b1, 1'b0, 6,  4'b1111, 16'd4};
    vt[10] = '{4'b1111, 1'b1, 1'b1, 1,  4'b1111, 16'd0};

    bus.noisy = '0; bus.tick = 1'b1; bus.glitch_clr = 1'b0;
    any_rise = '0; any_fall = '0;
    model_reset();
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("reset_state", {4'h0, bus.debounced, bus.rise, bus.fall, bus.glitch_count}, 32'h0);
    reset = 1'b0;

    // Table-driven vectors.
    for (int v = 0; v < 11; v++) begin
      bus.noisy = vt[v].noisy; bus.tick = vt[v].tick; bus.glitch_clr = vt[v].clr;
      for (int c = 0; c < vt[v].ncyc; c++) step();
      chk($sformatf("vec%0d_deb", v), 32'(bus.debounced), 32'(vt[v].exp_deb));
      chk($sformatf("vec%0d_gc", v), 32'(bus.glitch_count), 32'(vt[v].exp_gc));
    end
    bus.glitch_clr = 1'b0;

    // Clean press/release on channel 0 with exact edge timing.
    do_reset();
    bus.noisy = 4'b0001; bus.tick = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      if (e == 20) bus.noisy = 4'b0000;
      step();
      if (e == 6)  chk("press_e6_deb", 32'(bus.debounced), 32'h0);
      if (e == 7)  chk("press_e7", {bus.debounced, bus.rise}, 8'h11);
      if (e == 8)  chk("press_e8", {bus.debounced, bus.rise}, 8'h10);
      if (e == 24) chk("rel_e24_deb", 32'(bus.debounced), 32'h1);
      if (e == 25) chk("rel_e25", {bus.debounced, bus.fall}, 8'h01);
      if (e == 26) chk("rel_e26_fall", 32'(bus.fall), 32'h0);
    end
    chk("clean_gc", 32'(bus.glitch_count), 32'h0);

    // Press glitch on channel 1.
    do_reset();
    bus.noisy = 4'b0010; step(); step();
    bus.noisy = 4'b0000;
    for (int e = 0; e < 10; e++) step();
    chk("pglitch_deb_rise", {bus.debounced, any_rise}, 8'h00);
    chk("pglitch_gc", 32'(bus.glitch_count), 32'd1);

    // Release glitch on channel 2.
    do_reset();
    bus.noisy = 4'b0100;
    for (int e = 0; e < 8; e++) step();
    bus.noisy = 4'b0000; step();
    bus.noisy = 4'b0100;
    for (int e = 0; e < 8; e++) step();
    chk("rglitch_deb_fall", {bus.debounced, any_fall}, 8'h40);
    chk("rglitch_gc", 32'(bus.glitch_count), 32'd1);

    // Simultaneous aborts, saturation, and clear coinciding with aborts.
    do_reset();
    for (int r = 0; r < 16383; r++) begin
      bus.noisy = 4'b1111; step();
      bus.noisy = 4'b0000; step();
    end
    for (int e = 0; e < 4; e++) step();
    chk("sat_fffc", 32'(bus.glitch_count), 32'hFFFC);
    bus.noisy = 4'b0001; step();
    bus.noisy = 4'b0000; for (int e = 0; e < 4; e++) step();
    chk("sat_fffd", 32'(bus.glitch_count), 32'hFFFD);
    bus.noisy = 4'b1111; step();
    bus.noisy = 4'b0000; for (int e = 0; e < 4; e++) step();
    chk("sat_ffff", 32'(bus.glitch_count), 32'hFFFF);
    bus.noisy = 4'b1111; step();
    bus.noisy = 4'b0000; for (int e = 0; e < 4; e++) step();
    chk("sat_hold", 32'(bus.glitch_count), 32'hFFFF);
    bus.noisy = 4'b1111; step();
    bus.noisy = 4'b0000; step(); step();
    bus.glitch_clr = 1'b1; step();
    bus.glitch_clr = 1'b0;
    chk("clr_plus4", 32'(bus.glitch_count), 32'd4);

    // Async reset mid-PRESS with a held channel and nonzero count present.
    bus.noisy = 4'b1000;
    for (int e = 0; e < 10; e++) step();
    chk("pre_reset_deb", 32'(bus.debounced), 32'h8);
    bus.noisy = 4'b1001;
    for (int e = 0; e < 5; e++) step();
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 6) chk("rst_requal_e6", 32'(bus.debounced), 32'h0);
      if (e == 7) chk("rst_requal_e7", {bus.debounced, bus.rise}, 8'h99);
    end

    // Tick stall: alternate ticks stretch PRESS to 8 clocks; abort on a tick=0 cycle.
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      bus.tick  = (e % 2 == 1);
      bus.noisy = (e == 6) ? 4'b0001 : 4'b0011;
      step();
      if (e == 8)  chk("stall_abort_gc", 32'(bus.glitch_count), 32'd1);
      if (e == 10) chk("stall_e10_deb", 32'(bus.debounced), 32'h0);
      if (e == 11) chk("stall_e11_deb", 32'(bus.debounced), 32'h1);
    end
    bus.tick = 1'b1;

    // Randomized stimulus against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 11) == 0) bus.noisy[i] = ~bus.noisy[i];
      end
      bus.tick       = ($urandom_range(0, 3) != 0);
      bus.glitch_clr = ($urandom_range(0, 49) == 0);
      step();
      if (n % 1000 == 999) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent debounce channels (1..32).
REQ-002 SHALL have parameter PRESS_TICKS, default 1000000, stable-high ticks required to assert a channel (>=1).
REQ-003 SHALL have parameter RELEASE_TICKS, default 1000000, stable-low ticks required to deassert a channel (>=1).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port tick  input  1  timer advance enable; tie high for per-clock counting.
REQ-008 SHALL have port noisy  input  CHANNELS  raw asynchronous switch inputs.
REQ-009 SHALL have port glitch_clr  input  1  synchronous clear of glitch_count.
REQ-010 SHALL have port debounced  output  CHANNELS  registered debounced levels.
REQ-011 SHALL have port rise  output  CHANNELS  one-cycle pulse on the debounced 0->1 transition.
REQ-012 SHALL have port fall  output  CHANNELS  one-cycle pulse on the debounced 1->0 transition.
REQ-013 SHALL have port glitch_count  output  16  saturating count of aborted qualifications, all channels.

Function
REQ-014 SHALL pass each noisy bit through a SYNC_STAGES flop chain; s[i] denotes the last stage.
REQ-015 SHALL implement per channel a 4-state FSM: IDLE, PRESS, HELD, RELEASE, plus a private timer sized to ceil(log2(max(PRESS_TICKS,RELEASE_TICKS)+1)) bits.
REQ-016 SHALL, in IDLE: s=1 -> PRESS with timer=0; otherwise remain in IDLE.
REQ-017 SHALL, in PRESS: s=0 -> IDLE (abort); else tick=1 and timer==PRESS_TICKS-1 -> HELD; else timer increments when tick=1 and holds when tick=0.
REQ-018 SHALL, in HELD: s=0 -> RELEASE with timer=0; otherwise remain in HELD.
REQ-019 SHALL, in RELEASE: s=1 -> HELD (abort); else tick=1 and timer==RELEASE_TICKS-1 -> IDLE; else timer increments when tick=1 and holds when tick=0.
REQ-020 SHALL evaluate aborts every clock, independent of tick.
REQ-021 SHALL drive debounced[i]=1 exactly while channel i is in HELD or RELEASE.
REQ-022 SHALL assert rise[i] for exactly one cycle, coincident with the first cycle debounced[i]=1, and fall[i] likewise on the first cycle debounced[i]=0.
REQ-023 SHALL, with tick=1, assert debounced[i] after edge SYNC_STAGES+PRESS_TICKS+1, counting the edge that first samples noisy[i]=1 as edge 1, and deassert it after edge SYNC_STAGES+RELEASE_TICKS+1 by the same counting.
REQ-024 SHALL set glitch_count_next = (glitch_clr ? 0 : glitch_count) + number of channels aborting this cycle, saturating at 16'hFFFF.
REQ-025 SHALL keep channels fully independent; simultaneous events on different channels SHALL NOT interact except through glitch_count.

Reset
REQ-026 SHALL, on reset assertion, immediately force all synchroniser flops, timers, and outputs to 0, and all FSMs to IDLE, regardless of clk.
REQ-027 SHALL, after reset deassertion mid-qualification, require a full PRESS_TICKS qualification; no partial progress SHALL be retained.

Verification (CHANNELS=4, PRESS_TICKS=4, RELEASE_TICKS=3, SYNC_STAGES=2, tick=1 unless stated)
REQ-028 SHALL cover clean press/release: noisy[0] rises before edge 1 and is held -> debounced[0]=1 and rise[0]=1 after edge 7, rise[0]=0 after edge 8; noisy[0] falls before edge 20 -> debounced[0]=0 and fall[0]=1 after edge 25; glitch_count=0.
REQ-029 SHALL cover a press glitch: noisy[1] high for 2 cycles then low -> debounced[1] stays 0, no rise, glitch_count=1.
REQ-030 SHALL cover a release glitch: channel 2 in HELD, noisy[2] low for 1 cycle -> debounced[2] stays 1, no fall, glitch_count increments by 1.
REQ-031 SHALL cover simultaneous aborts: all 4 channels abort in the same cycle -> glitch_count +4; from 16'hFFFD -> 16'hFFFF; with glitch_clr=1 in that cycle -> 4.
REQ-032 SHALL cover async reset mid-PRESS: reset pulses after edge 5 of REQ-028 stimulus -> all outputs 0 without a clock edge; with noisy held high, debounced rises only after a full 2+4+1-edge qualification from reset release.
REQ-033 SHALL cover tick stall: tick=1 on alternate cycles only -> PRESS lasts 8 clocks; a 1-cycle low on noisy during a tick=0 cycle still aborts.
